// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the FPU datapath.
// Holds default field widths, the add/sub opcode encoding, the exponent
// bias helper, FP32 field-extract helpers and a few FP32 constants.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    typedef enum logic {
        FP_OP_ADD = 1'b0,
        FP_OP_SUB = 1'b1
    } fp_op_e;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic logic fp32_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp32_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp32_man(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp_norm_lzc.sv
// Combinational normaliser for the adder's final stage.
// Ports:
//   sum_i  : raw mantissa sum/difference, MAN_W+2 bits (bit MAN_W+1 = carry)
//   exp_i  : exponent of the larger operand
//   exp_o  : adjusted exponent
//   man_o  : normalised stored mantissa (hidden bit dropped)
//   zero_o : sum was exactly zero (caller forces +0)
module fp_norm_lzc
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic [MAN_W+1:0] sum_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic [EXP_W-1:0] exp_o,
    output logic [MAN_W-1:0] man_o,
    output logic             zero_o
);

    localparam int LZC_W = $clog2(MAN_W + 2);

    logic [LZC_W-1:0] lzc;
    logic [MAN_W:0]   shifted;

    always_comb begin
        // Highest set bit wins since it is written last.
        lzc = '0;
        for (int i = 0; i <= MAN_W; i++) begin
            if (sum_i[i]) lzc = LZC_W'(MAN_W - i);
        end
        shifted = sum_i[MAN_W:0] << lzc;
        zero_o  = (sum_i == '0);
        if (sum_i[MAN_W+1]) begin
            // Carry out: one right shift, the dropped LSB is truncated.
            exp_o = exp_i + EXP_W'(1);
            man_o = sum_i[MAN_W:1];
        end else begin
            exp_o = exp_i - EXP_W'(lzc);
            man_o = shifted[MAN_W-1:0];
        end
    end

endmodule

// File: rtl/fpadd_pipe.sv
// Pipelined floating-point add/subtract, fixed 4-cycle latency, 1 op/cycle.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   in_valid/in_ready       : operand handshake (in_ready is combinational)
//   in_op                   : 0 = A+B, 1 = A-B
//   in_a, in_b, in_tag      : operands {sign,exp,man} and routing tag
//   out_valid/out_ready     : result handshake
//   out_result, out_tag     : truncated sum/difference and its tag
// Stages: S1 op-apply + swap, S2 align, S3 add/sub, S4 normalise into the
// output register. The whole pipe advances together or holds together.
module fpadd_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_op,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int MW     = MAN_W + 1;
    localparam int SW     = MAN_W + 2;
    localparam int STAGES = 4;
    localparam logic [EXP_W-1:0] MAX_SH = EXP_W'(MAN_W + 1);

    // Zero operands take a bypass path carried alongside the arithmetic.
    typedef struct packed {
        logic             byp;
        logic [W-1:0]     bval;
        logic             sx;
        logic             sy;
        logic [EXP_W-1:0] ex;
        logic [EXP_W-1:0] ey;
        logic [MW-1:0]    mx;
        logic [MW-1:0]    my;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             byp;
        logic [W-1:0]     bval;
        logic             sx;
        logic             sub;
        logic [EXP_W-1:0] ex;
        logic [MW-1:0]    mx;
        logic [MW-1:0]    my;
        logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic             byp;
        logic [W-1:0]     bval;
        logic             sx;
        logic [EXP_W-1:0] ex;
        logic [SW-1:0]    sum;
        logic [TAG_W-1:0] tag;
    } s3_t;

    logic [STAGES:1] vld_q, vld_d;
    s1_t             s1_q, s1_d;
    s2_t             s2_q, s2_d;
    s3_t             s3_q, s3_d;
    logic [W-1:0]    res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic            advance;

    logic [W-1:0]     op_a, op_b, op_x, op_y;
    logic             a_zero, b_zero, a_ge;
    logic [EXP_W-1:0] sh;
    logic [EXP_W-1:0] n_exp;
    logic [MAN_W-1:0] n_man;
    logic             n_zero;

    assign advance    = ~vld_q[STAGES] | out_ready;
    assign in_ready   = advance;
    assign out_valid  = vld_q[STAGES];
    assign out_result = res_q;
    assign out_tag    = tag_q;

    assign vld_d = {vld_q[STAGES-1:1], in_valid};

    // S1: apply op to B, order by magnitude (A wins ties).
    assign op_a   = in_a;
    assign op_b   = {in_b[W-1] ^ (in_op == FP_OP_SUB), in_b[W-2:0]};
    assign a_zero = (op_a[W-2:MAN_W] == '0);
    assign b_zero = (op_b[W-2:MAN_W] == '0);
    assign a_ge   = (op_a[W-2:0] >= op_b[W-2:0]);
    assign op_x   = a_ge ? op_a : op_b;
    assign op_y   = a_ge ? op_b : op_a;

    always_comb begin
        s1_d      = '0;
        s1_d.byp  = a_zero | b_zero;
        s1_d.bval = a_zero ? op_b : op_a;
        s1_d.sx   = op_x[W-1];
        s1_d.sy   = op_y[W-1];
        s1_d.ex   = op_x[W-2:MAN_W];
        s1_d.ey   = op_y[W-2:MAN_W];
        s1_d.mx   = {1'b1, op_x[MAN_W-1:0]};
        s1_d.my   = {1'b1, op_y[MAN_W-1:0]};
        s1_d.tag  = in_tag;
    end

    // S2: align the smaller mantissa; bits shifted out are lost.
    assign sh = s1_q.ex - s1_q.ey;

    always_comb begin
        s2_d      = '0;
        s2_d.byp  = s1_q.byp;
        s2_d.bval = s1_q.bval;
        s2_d.sx   = s1_q.sx;
        s2_d.sub  = s1_q.sx ^ s1_q.sy;
        s2_d.ex   = s1_q.ex;
        s2_d.mx   = s1_q.mx;
        s2_d.my   = (sh > MAX_SH) ? '0 : (s1_q.my >> sh);
        s2_d.tag  = s1_q.tag;
    end

    // S3: magnitude add or subtract; X >= Y so the difference is never negative.
    always_comb begin
        s3_d      = '0;
        s3_d.byp  = s2_q.byp;
        s3_d.bval = s2_q.bval;
        s3_d.sx   = s2_q.sx;
        s3_d.ex   = s2_q.ex;
        s3_d.sum  = s2_q.sub ? ({1'b0, s2_q.mx} - {1'b0, s2_q.my})
                             : ({1'b0, s2_q.mx} + {1'b0, s2_q.my});
        s3_d.tag  = s2_q.tag;
    end

    // S4: normalise and pack.
    fp_norm_lzc #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm (
        .sum_i  (s3_q.sum),
        .exp_i  (s3_q.ex),
        .exp_o  (n_exp),
        .man_o  (n_man),
        .zero_o (n_zero)
    );

    always_comb begin
        if (s3_q.byp)   res_d = s3_q.bval;
        else if (n_zero) res_d = '0;
        else            res_d = {s3_q.sx, n_exp, n_man};
        tag_d = s3_q.tag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            res_q <= '0;
            tag_q <= '0;
        end else if (advance) begin
            vld_q <= vld_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            res_q <= res_d;
            tag_q <= tag_d;
        end
    end

endmodule

// File: tb/tb_fpadd_pipe.sv
// Self-checking bench for fpadd_pipe (FP32 defaults): directed vector table,
// latency/stall/reset sequences and a random scoreboard run against a
// truncating reference model.
module tb_fpadd_pipe;
    import fp_pkg::*;

    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid, in_ready, in_op;
    logic [31:0]       in_a, in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid, out_ready;
    logic [31:0]       out_result;
    logic [TAG_W-1:0]  out_tag;

    fpadd_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] res; logic [TAG_W-1:0] tag; } exp_t;
    typedef struct { logic op; logic [31:0] a; logic [31:0] b; logic [31:0] res; } vec_t;

    exp_t sb_q[$];
    exp_t sb_e;
    vec_t vt[16];
    int   n_chk = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;
    int   rdy_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Truncating reference: align with loss, add/sub magnitudes, renormalise.
    function automatic logic [31:0] ref_add(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bp, big, sml;
        longint      mb, ms, r;
        int          eb, es, d;
        bp = b ^ {op, 31'b0};
        if (fp32_exp(a) == 8'd0) return bp;
        if (fp32_exp(bp) == 8'd0) return a;
        if (a[30:0] >= bp[30:0]) begin big = a; sml = bp; end
        else begin big = bp; sml = a; end
        eb = int'(fp32_exp(big));
        es = int'(fp32_exp(sml));
        mb = longint'({1'b1, fp32_man(big)});
        ms = longint'({1'b1, fp32_man(sml)});
        d  = eb - es;
        ms = (d > 40) ? 64'sd0 : (ms >>> d);
        r  = (fp32_sign(big) == fp32_sign(sml)) ? mb + ms : mb - ms;
        if (r == 0) return 32'h0;
        while (r >= 64'sh100_0000) begin r = r >>> 1; eb++; end
        while (r < 64'sh80_0000) begin r = r <<< 1; eb--; end
        return {fp32_sign(big), 8'(eb), 23'(r)};
    endfunction

    function automatic logic [31:0] rnd_fp();
        if ($urandom_range(15) == 0) return {1'($urandom_range(1)), 31'b0};
        return {1'($urandom_range(1)), 8'($urandom_range(190, 64)), 23'($urandom)};
    endfunction

    // Output-ready driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1: begin
                    out_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
                    rdy_idx++;
                end
                default: out_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: scoreboard pops, ready relation, hold-while-stalled.
    logic             prev_stall = 1'b0;
    logic [31:0]      prev_res;
    logic [TAG_W-1:0] prev_tag;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_result", out_result, prev_res);
                check("hold_tag", 32'(out_tag), 32'(prev_tag));
            end
            if (out_valid) check("in_ready_eq_out_ready", 32'(in_ready), 32'(out_ready));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_result: got %h tag %h, expected no output", out_result, out_tag);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("result", out_result, sb_e.res);
                    check("tag", 32'(out_tag), 32'(sb_e.tag));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
            prev_tag   = out_tag;
        end
    end

    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] res);
        int waited = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        @(negedge clk);
        while (!in_ready && waited < 200) begin waited++; @(negedge clk); end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready got 0 for 200 cycles, expected 1");
            in_valid = 1'b0;
        end else begin
            sb_q.push_back('{res, tag});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int waited = 0;
        in_valid = 1'b0;
        while (sb_q.size() != 0 && waited < 500) begin @(posedge clk); #1; waited++; end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    // One op into an empty pipe with out_ready=1: valid exactly 4 edges later.
    task automatic latency_check(input string name, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1; in_op = 1'b0; in_a = FP32_ONE; in_b = FP32_ONE; in_tag = tag;
        @(negedge clk);
        check({name, "_accept"}, 32'(in_ready), 32'd1);
        sb_q.push_back('{32'h4000_0000, tag});
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check({name, "_valid_timing"}, 32'(out_valid), 32'(i == 4));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        op;
        logic [TAG_W-1:0] tag;

        in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; in_tag = '0;

        // Reset state.
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_result", out_result, 32'd0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Exact 4-cycle latency with tag echo.
        latency_check("t1", 4'hA);

        // Directed table, back-to-back.
        vt[0]  = '{1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000};
        vt[1]  = '{1'b1, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000};
        vt[2]  = '{1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h0000_0000};
        vt[3]  = '{1'b0, 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000};
        vt[4]  = '{1'b1, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000};
        vt[5]  = '{1'b0, 32'h0000_0000, 32'hC000_0000, 32'hC000_0000};
        vt[6]  = '{1'b1, 32'h3F80_0000, 32'h4040_0000, 32'hC000_0000};
        vt[7]  = '{1'b0, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000};
        vt[8]  = '{1'b0, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
        vt[9]  = '{1'b1, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
        vt[10] = '{1'b0, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
        vt[11] = '{1'b0, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
        vt[12] = '{1'b0, 32'h3F80_0000, 32'h3400_0000, 32'h3F80_0001};
        vt[13] = '{1'b0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFF};
        vt[14] = '{1'b1, 32'h3F80_0001, 32'h3F80_0000, 32'h3400_0000};
        vt[15] = '{1'b0, 32'h4000_0000, 32'hBF80_0000, 32'h3F80_0000};
        for (int i = 0; i < 16; i++) send(vt[i].op, vt[i].a, vt[i].b, 4'(i), vt[i].res);
        drain("table_drain");

        // Stream 8 ops under a 1,0,0,1 ready pattern.
        rdy_idx = 0;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            a = {1'b0, 8'(127 + i), 23'(i * 12345)};
            b = 32'h3FC0_0000;
            op = 1'(i % 2);
            send(op, a, b, 4'(i), ref_add(op, a, b));
        end
        drain("stall_drain");
        rdy_mode = 0;
        @(posedge clk); #1;

        // Reset with ops in flight, before the first result.
        send(1'b0, FP32_ONE, FP32_ONE, 4'h1, 32'h4000_0000);
        send(1'b0, FP32_ONE, FP32_ONE, 4'h2, 32'h4000_0000);
        send(1'b0, FP32_ONE, FP32_ONE, 4'h3, 32'h4000_0000);
        in_valid = 1'b0;
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_result", out_result, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postreset_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        latency_check("t5", 4'h5);

        // Random ops with random valid gaps and random out_ready.
        rdy_mode = 2;
        tag = '0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(4) == 0) idle();
            a = rnd_fp();
            case ($urandom_range(3))
                0: b = rnd_fp();
                1: b = {1'($urandom_range(1)), 8'(int'(fp32_exp(a) == 0 ? 8'd100 : fp32_exp(a)) - 2 + int'($urandom_range(4))), 23'($urandom)};
                2: b = {1'($urandom_range(1)), a[30:0]};
                default: b = {a[31:8], 8'($urandom)};
            endcase
            op = 1'($urandom_range(1));
            send(op, a, b, tag, ref_add(op, a, b));
            tag = tag + 1'b1;
        end
        drain("random_drain");
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
